// File: rtl/enigma_pkg.sv
// Shared definitions for the rotor stepping logic: alphabet size, rotor types,
// notch positions, FSM state encoding and position arithmetic helpers.
package enigma_pkg;

  localparam int ALPHABET_SIZE = 26;

  typedef enum logic [2:0] {
    ROTOR_I    = 3'd0,
    ROTOR_II   = 3'd1,
    ROTOR_III  = 3'd2,
    ROTOR_IV   = 3'd3,
    ROTOR_V    = 3'd4,
    ROTOR_VI   = 3'd5,
    ROTOR_VII  = 3'd6,
    ROTOR_VIII = 3'd7
  } rotor_t;

  // Pre-step positions at which a rotor carries into its left neighbour.
  localparam logic [4:0] NOTCH_I    = 5'd16;
  localparam logic [4:0] NOTCH_II   = 5'd4;
  localparam logic [4:0] NOTCH_III  = 5'd21;
  localparam logic [4:0] NOTCH_IV   = 5'd9;
  localparam logic [4:0] NOTCH_V    = 5'd25;
  localparam logic [4:0] NOTCH_NAVY_A = 5'd12;  // rotors VI..VIII, first notch
  localparam logic [4:0] NOTCH_NAVY_B = 5'd25;  // rotors VI..VIII, second notch

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EVAL = 2'd1;
  localparam state_t ST_STEP = 2'd2;

  // Advance one position with wrap 25 -> 0.
  function automatic logic [4:0] pos_inc(input logic [4:0] p);
    return (p >= 5'(ALPHABET_SIZE - 1)) ? 5'd0 : p + 5'd1;
  endfunction

  // Fold 26..31 back into 0..5 so stored positions never exceed 25.
  function automatic logic [4:0] pos_reduce(input logic [4:0] p);
    return (p >= 5'(ALPHABET_SIZE)) ? p - 5'(ALPHABET_SIZE) : p;
  endfunction

endpackage

// File: rtl/rotor_notch_decode.sv
// Combinational notch detector: flags when a rotor of the given type sits at
// one of its carry positions. Zero latency, no state.
module rotor_notch_decode
  import enigma_pkg::*;
(
  input  logic [4:0] pos,
  input  rotor_t     rtype,
  output logic       at_notch
);

  // Compare the position against the notch(es) of the selected rotor type.
  always_comb begin
    at_notch = 1'b0;
    case (rtype)
      ROTOR_I:   at_notch = (pos == NOTCH_I);
      ROTOR_II:  at_notch = (pos == NOTCH_II);
      ROTOR_III: at_notch = (pos == NOTCH_III);
      ROTOR_IV:  at_notch = (pos == NOTCH_IV);
      ROTOR_V:   at_notch = (pos == NOTCH_V);
      default:   at_notch = (pos == NOTCH_NAVY_A) || (pos == NOTCH_NAVY_B);
    endcase
  end

endmodule

// File: rtl/rotor_stepper.sv
// Three-rotor stepping FSM (IDLE -> EVAL -> STEP). A step accepted at edge n
// updates positions and pulses step_done at edge n+2; step_ready is low while
// busy and requests/loads arriving then are dropped, not queued.
// Build option: ROTOR_STEPPER_DOUBLE_STEP_EN enables the middle-rotor double step.
module rotor_stepper
  import enigma_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [2:0] load_type_l,
  input  logic [2:0] load_type_m,
  input  logic [2:0] load_type_r,
  input  logic [4:0] load_pos_l,
  input  logic [4:0] load_pos_m,
  input  logic [4:0] load_pos_r,
  input  logic       step_req,
  output logic       step_ready,
  output logic [4:0] pos_l,
  output logic [4:0] pos_m,
  output logic [4:0] pos_r,
  output logic       step_done
);

  state_t     state_q, state_d;
  rotor_t     type_l_q, type_l_d;
  rotor_t     type_m_q, type_m_d;
  rotor_t     type_r_q, type_r_d;
  logic [4:0] pos_l_q, pos_l_d;
  logic [4:0] pos_m_q, pos_m_d;
  logic [4:0] pos_r_q, pos_r_d;
  logic       notch_r_q, notch_r_d;
  logic       notch_m_q, notch_m_d;
  logic       done_q, done_d;
  logic       at_notch_r, at_notch_m;
  logic       mid_adv;

  // The leftmost rotor's notch never carries anywhere, so its type is held
  // only for completeness of the loaded configuration.
  logic       unused_type_l;
  assign unused_type_l = ^type_l_q;

  rotor_notch_decode u_notch_r (
    .pos      (pos_r_q),
    .rtype    (type_r_q),
    .at_notch (at_notch_r)
  );

  rotor_notch_decode u_notch_m (
    .pos      (pos_m_q),
    .rtype    (type_m_q),
    .at_notch (at_notch_m)
  );

`ifdef ROTOR_STEPPER_DOUBLE_STEP_EN
  // Historical behaviour: a middle rotor sitting on its notch drags itself along.
  assign mid_adv = notch_r_q | notch_m_q;
`else
  // Pure odometer: the middle rotor only moves on a carry from the right.
  assign mid_adv = notch_r_q;
`endif

  // Next-state logic; the left rotor follows notch_m in both builds.
  always_comb begin
    state_d   = state_q;
    type_l_d  = type_l_q;
    type_m_d  = type_m_q;
    type_r_d  = type_r_q;
    pos_l_d   = pos_l_q;
    pos_m_d   = pos_m_q;
    pos_r_d   = pos_r_q;
    notch_r_d = notch_r_q;
    notch_m_d = notch_m_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          // Load wins over a coincident step request.
          type_l_d = rotor_t'(load_type_l);
          type_m_d = rotor_t'(load_type_m);
          type_r_d = rotor_t'(load_type_r);
          pos_l_d  = pos_reduce(load_pos_l);
          pos_m_d  = pos_reduce(load_pos_m);
          pos_r_d  = pos_reduce(load_pos_r);
        end else if (step_req) begin
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        notch_r_d = at_notch_r;
        notch_m_d = at_notch_m;
        state_d   = ST_STEP;
      end
      ST_STEP: begin
        pos_r_d = pos_inc(pos_r_q);
        if (mid_adv)   pos_m_d = pos_inc(pos_m_q);
        if (notch_m_q) pos_l_d = pos_inc(pos_l_q);
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any step in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      type_l_q  <= ROTOR_I;
      type_m_q  <= ROTOR_I;
      type_r_q  <= ROTOR_I;
      pos_l_q   <= 5'd0;
      pos_m_q   <= 5'd0;
      pos_r_q   <= 5'd0;
      notch_r_q <= 1'b0;
      notch_m_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      type_l_q  <= type_l_d;
      type_m_q  <= type_m_d;
      type_r_q  <= type_r_d;
      pos_l_q   <= pos_l_d;
      pos_m_q   <= pos_m_d;
      pos_r_q   <= pos_r_d;
      notch_r_q <= notch_r_d;
      notch_m_q <= notch_m_d;
      done_q    <= done_d;
    end
  end

  assign step_ready = (state_q == ST_IDLE);
  assign pos_l      = pos_l_q;
  assign pos_m      = pos_m_q;
  assign pos_r      = pos_r_q;
  assign step_done  = done_q;

endmodule

// File: tb/tb_rotor_stepper.sv
// Directed bench for rotor_stepper: reset, loading, stepping sequences,
// wrap/notch cases, load-vs-step priority and step timing.
module tb_rotor_stepper;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [2:0] load_type_l, load_type_m, load_type_r;
  logic [4:0] load_pos_l, load_pos_m, load_pos_r;
  logic       step_req;
  logic       step_ready;
  logic [4:0] pos_l, pos_m, pos_r;
  logic       step_done;

  int vec_cnt = 0;
  int err_cnt = 0;

  rotor_stepper dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .load_type_l (load_type_l),
    .load_type_m (load_type_m),
    .load_type_r (load_type_r),
    .load_pos_l  (load_pos_l),
    .load_pos_m  (load_pos_m),
    .load_pos_r  (load_pos_r),
    .step_req    (step_req),
    .step_ready  (step_ready),
    .pos_l       (pos_l),
    .pos_m       (pos_m),
    .pos_r       (pos_r),
    .step_done   (step_done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    vec_cnt++;
    if (obs != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_pos(input string tag, input int l, input int m, input int r);
    check_val({tag, ".l"}, int'(pos_l), l);
    check_val({tag, ".m"}, int'(pos_m), m);
    check_val({tag, ".r"}, int'(pos_r), r);
  endtask

  // One-cycle load pulse in IDLE; returns at the following falling edge.
  task automatic do_load(input logic [2:0] tl, input logic [2:0] tm, input logic [2:0] tr,
                         input logic [4:0] pl, input logic [4:0] pm, input logic [4:0] pr);
    load_type_l = tl; load_type_m = tm; load_type_r = tr;
    load_pos_l  = pl; load_pos_m  = pm; load_pos_r  = pr;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Single-cycle step request; waits (bounded) for step_done and checks latency.
  task automatic do_step(input string tag);
    int n;
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    n = 0;
    while (!step_done && n < 8) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, ".done"}, int'(step_done), 1);
    check_val({tag, ".lat"}, n, 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; load = 1'b0; step_req = 1'b0;
    load_type_l = '0; load_type_m = '0; load_type_r = '0;
    load_pos_l = '0; load_pos_m = '0; load_pos_r = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check_pos("rst", 0, 0, 0);
    check_val("rst.done", int'(step_done), 0);
    check_val("rst.ready", int'(step_ready), 1);

    // Reset during STEP aborts the step
    step_req = 1'b1;
    @(negedge clk);              // EVAL
    step_req = 1'b0;
    @(negedge clk);              // STEP
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_val("abort.done", int'(step_done), 0);
      @(negedge clk);
    end
    check_pos("abort", 0, 0, 0);
    check_val("abort.ready", int'(step_ready), 1);

    // Notch/double-step sequence: L=I M=II R=III at (0,3,20)
    do_load(3'd0, 3'd1, 3'd2, 5'd0, 5'd3, 5'd20);
    check_pos("ds.load", 0, 3, 20);
    do_step("ds1"); check_pos("ds1", 0, 3, 21);
    @(negedge clk);
    do_step("ds2"); check_pos("ds2", 0, 4, 22);
    @(negedge clk);
    do_step("ds3");
`ifdef ROTOR_STEPPER_DOUBLE_STEP_EN
    check_pos("ds3", 1, 5, 23);
`else
    // Middle stays on its notch; the left rotor still follows notch_m.
    check_pos("ds3", 1, 4, 23);
`endif
    @(negedge clk);

    // Wrap: 25 is not a type I notch
    do_load(3'd0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd25);
    do_step("wrapI"); check_pos("wrapI", 0, 0, 0);
    @(negedge clk);
    // Wrap: 25 is the type V notch
    do_load(3'd0, 3'd0, 3'd4, 5'd0, 5'd0, 5'd25);
    do_step("wrapV"); check_pos("wrapV", 0, 1, 0);
    @(negedge clk);
    // Navy rotor at 12 carries; middle type VI at 25 also wraps left/middle
    do_load(3'd0, 3'd5, 3'd7, 5'd25, 5'd25, 5'd12);
    do_step("navy");
`ifdef ROTOR_STEPPER_DOUBLE_STEP_EN
    check_pos("navy", 0, 0, 13);
`else
    check_pos("navy", 0, 0, 13);
`endif
    @(negedge clk);

    // Out-of-range load values are reduced mod 26
    do_load(3'd0, 3'd0, 3'd0, 5'd27, 5'd31, 5'd26);
    check_pos("mod26", 1, 5, 0);

    // Simultaneous load and step: load wins, no step follows
    load_type_l = 3'd0; load_type_m = 3'd0; load_type_r = 3'd0;
    load_pos_l = 5'd7; load_pos_m = 5'd8; load_pos_r = 5'd9;
    load = 1'b1; step_req = 1'b1;
    @(negedge clk);
    load = 1'b0; step_req = 1'b0;
    check_pos("ldstep", 7, 8, 9);
    for (int i = 0; i < 3; i++) begin
      check_val("ldstep.done", int'(step_done), 0);
      check_val("ldstep.ready", int'(step_ready), 1);
      @(negedge clk);
    end
    check_pos("ldstep.after", 7, 8, 9);

    // Timing with step_req held, plus a load while busy that must be ignored
    step_req = 1'b1;
    @(negedge clk);                                  // after edge n (EVAL)
    check_val("t.n1.ready", int'(step_ready), 0);
    check_val("t.n1.done", int'(step_done), 0);
    load_pos_r = 5'd2; load = 1'b1;
    @(negedge clk);                                  // after edge n+1 (STEP)
    load = 1'b0;
    check_val("t.n2.ready", int'(step_ready), 0);
    check_val("t.n2.done", int'(step_done), 0);
    check_pos("t.n2", 7, 8, 9);
    @(negedge clk);                                  // after edge n+2
    step_req = 1'b0;
    check_val("t.n3.done", int'(step_done), 1);
    check_val("t.n3.ready", int'(step_ready), 1);
    check_pos("t.n3", 7, 8, 10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("t.extra.done", int'(step_done), 0);
    end
    check_pos("t.after", 7, 8, 10);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
